// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Groups the cache-side read/write handshakes and the single-port RAM bus
//   of mem_responder into one bundle.
//   Modports:
//     slave  - responder view: requests and RAM read data in; done, line and
//              RAM controls out.
//     master - requester / RAM view (the mirror image).
//   Optional: o_mem_err exists only when MEM_RESP_RANGE_CHECK_EN is defined.
interface mem_responder_if #(
   parameter int DATA_WIDTH       = 64,
   parameter int ADDR_WIDTH       = 64,
   parameter int CACHE_LINE_WIDTH = 256,
   parameter int RAM_ADDR_WIDTH   = 14
);
   logic                        i_mem_read_req;
   logic [ADDR_WIDTH-1:0]       i_mem_read_address;
   logic                        o_mem_read_done;
   logic [CACHE_LINE_WIDTH-1:0] o_cache_line;
   logic                        i_mem_write_valid;
   logic [ADDR_WIDTH-1:0]       i_mem_write_address;
   logic [DATA_WIDTH-1:0]       i_mem_write_data;
   logic [DATA_WIDTH/8-1:0]     i_write_strobe;
   logic                        o_mem_write_done;
   logic                        o_ram_en;
   logic [DATA_WIDTH/8-1:0]     o_ram_we;
   logic [RAM_ADDR_WIDTH-1:0]   o_ram_addr;
   logic [DATA_WIDTH-1:0]       o_ram_wdata;
   logic [DATA_WIDTH-1:0]       i_ram_rdata;
`ifdef MEM_RESP_RANGE_CHECK_EN
   logic                        o_mem_err;
`endif

   modport slave (
      input  i_mem_read_req, i_mem_read_address, i_mem_write_valid,
             i_mem_write_address, i_mem_write_data, i_write_strobe, i_ram_rdata,
`ifdef MEM_RESP_RANGE_CHECK_EN
      output o_mem_err,
`endif
      output o_mem_read_done, o_cache_line, o_mem_write_done,
             o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
   );

   modport master (
      output i_mem_read_req, i_mem_read_address, i_mem_write_valid,
             i_mem_write_address, i_mem_write_data, i_write_strobe, i_ram_rdata,
`ifdef MEM_RESP_RANGE_CHECK_EN
      input  o_mem_err,
`endif
      input  o_mem_read_done, o_cache_line, o_mem_write_done,
             o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder between the cache-request translator and a
//   single-port synchronous RAM. A read returns a full cache line built from
//   BEATS sequential word reads; a write is a single byte-strobed word write.
//   Both channels use a level (four-phase) req/done handshake; write wins
//   when both are pending in IDLE.
//   Ports:
//     i_clk    - clock, rising edge
//     i_rst_n  - asynchronous active-low reset (aborts any transaction)
//     bus      - mem_responder_if.slave: read/write handshakes, assembled
//                line, RAM en/we/addr/wdata and RAM read data
//   Optional: MEM_RESP_RANGE_CHECK_EN adds o_mem_err; out-of-range accesses
//   skip the RAM and finish with err raised alongside done.
module mem_responder #(
   parameter int DATA_WIDTH       = 64,
   parameter int ADDR_WIDTH       = 64,
   parameter int CACHE_LINE_WIDTH = 256,
   parameter int RAM_ADDR_WIDTH   = 14,
   parameter int RAM_LATENCY      = 1
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   mem_responder_if.slave bus
);
   localparam int BEATS  = CACHE_LINE_WIDTH / DATA_WIDTH;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int STAGES = RAM_LATENCY - 1;

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DRAIN, RD_DONE, WR, WR_DONE} state_t;
   state_t state_q, state_d;

   logic [RAM_ADDR_WIDTH-1:0]        addr_q;
   logic [DATA_WIDTH-1:0]            wdata_q;
   logic [STRB_W-1:0]                strb_q;
   logic [CNT_W-1:0]                 iss_cnt, ret_cnt;
   // vld_pipe[i] marks a read issued i+1 cycles ago; the top stage lines up
   // with valid RAM data.
   logic [STAGES:0]                  vld_pipe;
   logic [BEATS-1:0][DATA_WIDTH-1:0] line_q;

   logic [RAM_ADDR_WIDTH-1:0] rd_word, wr_word;
   logic                      rd_oob, wr_oob;

   logic                      ram_en, rd_done, wr_done;
   logic [STRB_W-1:0]         ram_we;
   logic [RAM_ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0]     ram_wdata;

   // Higher address bits are dropped, so accesses wrap modulo the RAM size.
   assign rd_word = bus.i_mem_read_address[RAM_ADDR_WIDTH+2:3] & ~RAM_ADDR_WIDTH'(BEATS-1);
   assign wr_word = bus.i_mem_write_address[RAM_ADDR_WIDTH+2:3];

`ifdef MEM_RESP_RANGE_CHECK_EN
   logic err_q;
   assign rd_oob = |bus.i_mem_read_address[ADDR_WIDTH-1:RAM_ADDR_WIDTH+3];
   assign wr_oob = |bus.i_mem_write_address[ADDR_WIDTH-1:RAM_ADDR_WIDTH+3];
   assign bus.o_mem_err = err_q & (rd_done | wr_done);
`else
   assign rd_oob = 1'b0;
   assign wr_oob = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      ram_en    = 1'b0;
      ram_we    = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      rd_done   = 1'b0;
      wr_done   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_mem_write_valid)   state_d = wr_oob ? WR_DONE : WR;
            else if (bus.i_mem_read_req) state_d = rd_oob ? RD_DONE : RD_ISSUE;
         end
         RD_ISSUE: begin
            ram_en   = 1'b1;
            ram_addr = addr_q + RAM_ADDR_WIDTH'(iss_cnt);
            if (iss_cnt == CNT_W'(BEATS-1)) state_d = RD_DRAIN;
         end
         RD_DRAIN: begin
            // Leave on the edge that captures the final beat.
            if (vld_pipe[STAGES] && ret_cnt == CNT_W'(BEATS-1)) state_d = RD_DONE;
         end
         RD_DONE: begin
            rd_done = 1'b1;
            if (!bus.i_mem_read_req) state_d = IDLE;
         end
         WR: begin
            ram_en    = 1'b1;
            ram_we    = strb_q;
            ram_addr  = addr_q;
            ram_wdata = wdata_q;
            state_d   = WR_DONE;
         end
         WR_DONE: begin
            wr_done = 1'b1;
            if (!bus.i_mem_write_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         strb_q   <= '0;
         iss_cnt  <= '0;
         ret_cnt  <= '0;
         vld_pipe <= '0;
         line_q   <= '0;
`ifdef MEM_RESP_RANGE_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         vld_pipe <= (STAGES+1)'({vld_pipe, state_q == RD_ISSUE});
         if (state_q == IDLE) begin
            if (bus.i_mem_write_valid) begin
               addr_q  <= wr_word;
               wdata_q <= bus.i_mem_write_data;
               strb_q  <= bus.i_write_strobe;
`ifdef MEM_RESP_RANGE_CHECK_EN
               err_q   <= wr_oob;
`endif
            end else if (bus.i_mem_read_req) begin
               addr_q  <= rd_word;
               iss_cnt <= '0;
               ret_cnt <= '0;
`ifdef MEM_RESP_RANGE_CHECK_EN
               err_q   <= rd_oob;
`endif
            end
         end
         if (state_q == RD_ISSUE) iss_cnt <= iss_cnt + 1'b1;
         // Returns arrive in issue order, so a plain counter selects the beat.
         if (vld_pipe[STAGES]) begin
            line_q[ret_cnt] <= bus.i_ram_rdata;
            ret_cnt         <= ret_cnt + 1'b1;
         end
      end
   end

   assign bus.o_mem_read_done  = rd_done;
   assign bus.o_mem_write_done = wr_done;
   assign bus.o_cache_line     = line_q;
   assign bus.o_ram_en         = ram_en;
   assign bus.o_ram_we         = ram_we;
   assign bus.o_ram_addr       = ram_addr;
   assign bus.o_ram_wdata      = ram_wdata;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Self-checking bench for mem_responder: one instance with RAM_LATENCY=1
//   and one with RAM_LATENCY=3, each backed by a behavioural RAM. Read lines
//   are predicted from a shadow memory when a request is driven, queued, and
//   compared when done rises.
module tb_mem_responder;
   localparam int DW = 64, AW = 64, LW = 256, RAW = 14;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_LINE_WIDTH(LW), .RAM_ADDR_WIDTH(RAW)) bus ();
   mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_LINE_WIDTH(LW), .RAM_ADDR_WIDTH(RAW)) bus3 ();

   mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_LINE_WIDTH(LW),
                   .RAM_ADDR_WIDTH(RAW), .RAM_LATENCY(1))
      dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
   mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_LINE_WIDTH(LW),
                   .RAM_ADDR_WIDTH(RAW), .RAM_LATENCY(3))
      dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3));

   // Behavioural RAMs with a side load port used only while the DUT is idle.
   logic [DW-1:0]  mem  [0:(1<<RAW)-1];
   logic [DW-1:0]  mem3 [0:(1<<RAW)-1];
   logic           ld_en = 1'b0, ld3_en = 1'b0;
   logic [RAW-1:0] ld_addr = '0;
   logic [DW-1:0]  ld_data = '0;
   logic [DW-1:0]  rd1 = '0, r31 = '0, r32 = '0, r33 = '0;

   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (bus.o_ram_en)
         for (int b = 0; b < 8; b++)
            if (bus.o_ram_we[b]) mem[bus.o_ram_addr][8*b +: 8] <= bus.o_ram_wdata[8*b +: 8];
      if (bus.o_ram_en) rd1 <= mem[bus.o_ram_addr];
   end
   assign bus.i_ram_rdata = rd1;

   always @(posedge clk) begin
      if (ld3_en) mem3[ld_addr] <= ld_data;
      if (bus3.o_ram_en) r31 <= mem3[bus3.o_ram_addr];
      r32 <= r31;
      r33 <= r32;
   end
   assign bus3.i_ram_rdata = r33;

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Shadow of RAM words 0..15 of the latency-1 RAM.
   logic [DW-1:0] shadow [16];

   function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
      int b;
      b = int'(a[6:5]) * 4;
      return {shadow[b+3], shadow[b+2], shadow[b+1], shadow[b]};
   endfunction

   task automatic shadow_wr(input int w, input logic [DW-1:0] d, input logic [7:0] s);
      for (int b = 0; b < 8; b++)
         if (s[b]) shadow[w][8*b +: 8] = d[8*b +: 8];
   endtask

   // Scoreboard: expected lines pushed at request time, popped on done rise.
   logic [LW-1:0] rd_q[$], rd3_q[$];
   logic rd_done_d = 1'b0, rd3_done_d = 1'b0;
   int   en3_cnt = 0;
   logic [RAW-1:0] ad3_q[$];

   always @(posedge clk) begin
      #1;
      if (bus.o_mem_read_done && !rd_done_d) begin
         chk("rd_expected", rd_q.size() != 0, 1'b1);
         if (rd_q.size() != 0) chk("rd_line", bus.o_cache_line, rd_q.pop_front());
      end
      if (bus3.o_mem_read_done && !rd3_done_d) begin
         chk("rd3_expected", rd3_q.size() != 0, 1'b1);
         if (rd3_q.size() != 0) chk("rd3_line", bus3.o_cache_line, rd3_q.pop_front());
      end
      rd_done_d  <= bus.o_mem_read_done;
      rd3_done_d <= bus3.o_mem_read_done;
   end

   always @(negedge clk) begin
      if (bus3.o_ram_en) begin
         en3_cnt <= en3_cnt + 1;
         ad3_q.push_back(bus3.o_ram_addr);
      end
   end

   task automatic preload(input int sel, input int idx, input logic [DW-1:0] d);
      ld_addr = RAW'(idx);
      ld_data = d;
      if (sel == 0) begin
         ld_en = 1'b1;
         if (idx < 16) shadow[idx] = d;
      end else ld3_en = 1'b1;
      @(posedge clk); #1;
      ld_en  = 1'b0;
      ld3_en = 1'b0;
   endtask

   task automatic rd_txn(input logic [AW-1:0] a);
      int lat;
      rd_q.push_back(line_of(a));
      bus.i_mem_read_address = a;
      bus.i_mem_read_req     = 1'b1;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end
      while (!bus.o_mem_read_done && lat < 40);
      chk("rd_lat", lat, 6);
      repeat (2) begin @(posedge clk); #1; chk("rd_hold", bus.o_mem_read_done, 1'b1); end
      bus.i_mem_read_req = 1'b0;
      @(posedge clk); #1;
      chk("rd_drop", bus.o_mem_read_done, 1'b0);
   endtask

   task automatic wr_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] s);
      int lat, w;
      w = int'(a[6:3]);
      shadow_wr(w, d, s);
      bus.i_mem_write_address = a;
      bus.i_mem_write_data    = d;
      bus.i_write_strobe      = s;
      bus.i_mem_write_valid   = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
         if (lat == 1) begin
            chk("wr_en", bus.o_ram_en, 1'b1);
            chk("wr_we", bus.o_ram_we, s);
            chk("wr_addr", bus.o_ram_addr, a[RAW+2:3]);
            chk("wr_data", bus.o_ram_wdata, d);
         end
      end while (!bus.o_mem_write_done && lat < 40);
      chk("wr_lat", lat, 2);
      chk("wr_ram", mem[w], shadow[w]);
      @(posedge clk); #1;
      chk("wr_hold", bus.o_mem_write_done, 1'b1);
      chk("wr_idle_en", bus.o_ram_en, 1'b0);
      bus.i_mem_write_valid = 1'b0;
      @(posedge clk); #1;
      chk("wr_drop", bus.o_mem_write_done, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, w;
      logic [LW-1:0] e3;
      bus.i_mem_read_req = 1'b0;  bus.i_mem_read_address = '0;
      bus.i_mem_write_valid = 1'b0; bus.i_mem_write_address = '0;
      bus.i_mem_write_data = '0;  bus.i_write_strobe = '0;
      bus3.i_mem_read_req = 1'b0; bus3.i_mem_read_address = '0;
      bus3.i_mem_write_valid = 1'b0; bus3.i_mem_write_address = '0;
      bus3.i_mem_write_data = '0; bus3.i_write_strobe = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_done", bus.o_mem_read_done, 1'b0);
      chk("rst_wr_done", bus.o_mem_write_done, 1'b0);
      chk("rst_en", bus.o_ram_en, 1'b0);
      chk("rst_we", bus.o_ram_we, 8'h00);
      chk("rst_addr", bus.o_ram_addr, '0);
      chk("rst_wdata", bus.o_ram_wdata, '0);
      chk("rst_line", bus.o_cache_line, '0);
      chk("rst3_line", bus3.o_cache_line, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) preload(0, i, {32'(i), 32'hC0DE_0000});
      preload(0, 8,  64'h1111_1111_1111_1111);
      preload(0, 9,  64'h2222_2222_2222_2222);
      preload(0, 10, 64'h3333_3333_3333_3333);
      preload(0, 11, 64'h4444_4444_4444_4444);

      // Aligned line read.
      rd_txn(64'h40);

      // Strobed write over an all-ones word.
      preload(0, 9, '1);
      wr_txn(64'h48, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
      chk("wr_word9", mem[9], 64'hFFFF_FFFF_CAFE_F00D);

      // Zero strobe: handshake completes, memory untouched.
      wr_txn(64'h50, 64'h0123_4567_89AB_CDEF, 8'h00);
      chk("wr_strb0_word10", mem[10], 64'h3333_3333_3333_3333);

      // Simultaneous write and read to the same line: write first.
      shadow_wr(4, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
      rd_q.push_back(line_of(64'h20));
      bus.i_mem_write_address = 64'h20;
      bus.i_mem_write_data    = 64'hA5A5_5A5A_0F0F_F0F0;
      bus.i_write_strobe      = 8'hFF;
      bus.i_mem_write_valid   = 1'b1;
      bus.i_mem_read_address  = 64'h20;
      bus.i_mem_read_req      = 1'b1;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end
      while (!bus.o_mem_write_done && lat < 40);
      chk("sim_wr_lat", lat, 2);
      chk("sim_rd_wait", bus.o_mem_read_done, 1'b0);
      bus.i_mem_write_valid = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end
      while (!bus.o_mem_read_done && lat < 40);
      chk("sim_rd_seen", bus.o_mem_read_done, 1'b1);
      bus.i_mem_read_req = 1'b0;
      @(posedge clk); #1;

      // Unaligned read maps to the 0x40 line.
      rd_txn(64'h5C);

      // Reset while issuing beat 2: immediate zero outputs, no done.
      bus.i_mem_read_address = 64'h40;
      bus.i_mem_read_req     = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("abort_pre_en", bus.o_ram_en, 1'b1);
      chk("abort_pre_addr", bus.o_ram_addr, 14'd10);
      rst_n = 1'b0;
      #1;
      chk("abort_en", bus.o_ram_en, 1'b0);
      chk("abort_addr", bus.o_ram_addr, '0);
      chk("abort_done", bus.o_mem_read_done, 1'b0);
      chk("abort_line", bus.o_cache_line, '0);
      bus.i_mem_read_req = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      repeat (8) begin @(posedge clk); #1; chk("abort_no_done", bus.o_mem_read_done, 1'b0); end
      rd_txn(64'h40);

      // Latency-3 instance: line from word 0, four issues in order.
      for (int i = 0; i < 4; i++) preload(1, i, {32'hB0B0_B0B0, 32'(i)});
      e3 = {32'hB0B0_B0B0, 32'd3, 32'hB0B0_B0B0, 32'd2, 32'hB0B0_B0B0, 32'd1, 32'hB0B0_B0B0, 32'd0};
      rd3_q.push_back(e3);
      bus3.i_mem_read_address = 64'h0;
      bus3.i_mem_read_req     = 1'b1;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end
      while (!bus3.o_mem_read_done && lat < 40);
      chk("rd3_lat", lat, 8);
      chk("rd3_en_cycles", en3_cnt, 4);
      chk("rd3_issue_count", ad3_q.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < ad3_q.size()) chk("rd3_issue_addr", ad3_q[k], k);
      bus3.i_mem_read_req = 1'b0;
      @(posedge clk); #1;
      chk("rd3_drop", bus3.o_mem_read_done, 1'b0);

      // A few random write-then-read pairs in the low 16 words.
      for (int n = 0; n < 4; n++) begin
         w = int'($urandom_range(0, 15));
         wr_txn(64'(w * 8), {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
         rd_txn(64'(w * 8 + int'($urandom_range(0, 7))));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", rd_q.size() + rd3_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
